rob: RTL
========

// Module: rob
// PURPOSE
//  Reorder buffer for the R10K-style out-of-order core. Sits upstream of the retirement map.
//  - Allocates one entry per dispatched instruction, holding its new tag T and previous tag Told.
//  - Marks entries complete from the CDB tag broadcast.
//  - Retires the head entry in program order, driving retire_t, retire_t_old and retire_en
//    to the retirement map; Told also goes to the free list.
// PARAMETERS
//  ROB_SZ       32  entries; power of two, >= 2
//  PHYS_REG_SZ  64  physical registers; sets width of TAG.phys_reg
// PORTS
//  clock             in   1                clock; all state updates on posedge
//  reset             in   1                synchronous, active-high
//  dispatch_en       in   1                allocate one entry this cycle
//  dispatch_t        in   TAG              new physical tag T for the destination
//  dispatch_t_old    in   TAG              previous mapping Told for the destination
//  dispatch_dest_idx in   5                architectural destination register
//  dispatch_idx      out  $clog2(ROB_SZ)   entry index given to the dispatching instr (= tail)
//  full              out  1                count == ROB_SZ
//  empty             out  1                count == 0
//  complete_en       in   1                CDB broadcast valid
//  complete_t        in   TAG              CDB tag
//  squash_en         in   1                flush all entries (mispredict / exception)
//  retire_en         out  1                head entry retires this cycle
//  retire_t          out  TAG              head T
//  retire_t_old      out  TAG              head Told
//  retire_dest_idx   out  5                head architectural destination
// BEHAVIOUR
//  - State: entry array {valid, complete, T, Told, dest_idx}[ROB_SZ].
//    head/tail pointers with an extra wrap bit; count is $clog2(ROB_SZ)+1 bits.
//  - Reset: every valid/complete bit = 0, head = tail = 0, count = 0.
//    Outputs after reset: full=0, empty=1, retire_en=0, retire_* = 0, dispatch_idx=0.
//  - Retire is combinational from the head:
//      retire_en = valid[head] & complete[head] & !squash_en & !reset.
//    retire_t/t_old/dest_idx = head fields when retire_en=1, else 0.
//    On posedge with retire_en: clear valid[head], head++ (wraps ROB_SZ-1 -> 0 and toggles the wrap bit).
//    At most one retire per cycle.
//  - Dispatch: accepted iff dispatch_en & !full & !squash_en.
//    On accept: entry[tail] <= {1, 0, dispatch_t, dispatch_t_old, dispatch_dest_idx}, tail++ with wrap.
//    full uses registered count; a same-cycle retire does NOT free a slot for dispatch.
//    Dispatch while full is dropped silently; upstream must stall on full.
//  - Complete: when complete_en, every entry with valid=1 and T.phys_reg == complete_t.phys_reg
//    sets complete <= 1.
//    Matching uses pre-edge valid bits, so the entry dispatched in the same cycle is not matched.
//    A CDB tag with no match has no effect.
//    Completing the head makes retire_en=1 on the NEXT cycle: one-cycle complete->retire latency.
//  - count: next = count + dispatch_accept - retire_en; simultaneous dispatch and retire leaves count unchanged.
//  - Squash: squash_en has priority over dispatch, complete and retire.
//    Next state equals the reset state.
//    The ROB never restores maps; the retirement map supplies the recovery state.
//  - Empty: retire_en=0. A complete broadcast while empty has no effect.
//  - Reset mid-operation: all in-flight entries are discarded, with no retire pulse.
// STRUCTURE
//  - Shared package (sys_defs): TAG struct {phys_reg}, ROB_SZ, PHYS_REG_SZ, ROB_IDX_W.
//  - No sub-module. Pointer/count logic and the CAM compare live inline in one always_ff
//    plus combinational retire logic.
// TESTING
//  - Reset, then idle: empty=1, full=0, retire_en=0, dispatch_idx=0 for 5 cycles.
//  - Dispatch T=33, Told=1, dest=1; CDB 33 next cycle -> retire_en=1 one cycle later with
//    retire_t=33, retire_t_old=1, retire_dest_idx=1; then empty=1.
//  - Dispatch T=40,41,42; complete 42, 41, then 40 -> no retire until 40 completes.
//    Then retires of 40, 41, 42 on three consecutive cycles, in that order.
//  - Fill 32 entries -> full=1. The 33rd dispatch is dropped and count stays 32.
//    Complete the head, retire it, and dispatch again: tail wraps, dispatch_idx=0, full=1 again.
//  - Completed head plus dispatch_en in the same cycle -> count unchanged, head and tail both advance.
//  - With 4 valid entries and the head complete, assert squash_en -> retire_en=0 that cycle.
//    Next cycle empty=1, and dispatch_idx=0 on the next dispatch.

Source files
------------

// File: rtl/sys_defs.sv
// Shared core definitions: physical tag type and reorder buffer sizing.
// Imported by the ROB and by its neighbours in the out-of-order core.
package sys_defs;

    localparam int unsigned ROB_SZ      = 32;
    localparam int unsigned PHYS_REG_SZ = 64;
    localparam int unsigned ROB_IDX_W   = $clog2(ROB_SZ);
    localparam int unsigned PHYS_IDX_W  = $clog2(PHYS_REG_SZ);

    // Occupancy count carries one extra bit so that a full buffer is representable.
    localparam logic [ROB_IDX_W:0] ROB_COUNT_FULL = (ROB_IDX_W + 1)'(ROB_SZ);

    typedef struct packed {
        logic [PHYS_IDX_W-1:0] phys_reg;
    } TAG;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate at the tail, CDB-driven completion, in-order retire
// from the head toward the retirement map and free list. Squash empties the buffer.
module rob
    import sys_defs::*;
(
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 dispatch_en,
    input  TAG                   dispatch_t,
    input  TAG                   dispatch_t_old,
    input  logic [4:0]           dispatch_dest_idx,
    output logic [ROB_IDX_W-1:0] dispatch_idx,
    output logic                 full,
    output logic                 empty,

    input  logic                 complete_en,
    input  TAG                   complete_t,

    input  logic                 squash_en,

    output logic                 retire_en,
    output TAG                   retire_t,
    output TAG                   retire_t_old,
    output logic [4:0]           retire_dest_idx
);

    logic [ROB_SZ-1:0]    r_valid;
    logic [ROB_SZ-1:0]    r_complete;
    TAG                   r_t       [ROB_SZ];
    TAG                   r_t_old   [ROB_SZ];
    logic [4:0]           r_dest    [ROB_SZ];

    // Pointers carry a wrap bit above the index.
    logic [ROB_IDX_W:0]   r_head;
    logic [ROB_IDX_W:0]   r_tail;
    logic [ROB_IDX_W:0]   r_count;

    logic [ROB_IDX_W-1:0] w_head_idx;
    logic [ROB_IDX_W-1:0] w_tail_idx;
    logic                 w_dispatch_accept;
    logic [ROB_SZ-1:0]    w_cam_hit;
    logic [ROB_IDX_W:0]   w_count_next;

    assign w_head_idx = r_head[ROB_IDX_W-1:0];
    assign w_tail_idx = r_tail[ROB_IDX_W-1:0];

    assign full         = (r_count == ROB_COUNT_FULL);
    assign empty        = (r_count == '0);
    assign dispatch_idx = w_tail_idx;

    // Registered count gates dispatch, so a same-cycle retire never frees the slot early.
    assign w_dispatch_accept = dispatch_en & ~full & ~squash_en;

    assign retire_en = r_valid[w_head_idx] & r_complete[w_head_idx] & ~squash_en & ~reset;

    always_comb begin
        retire_t        = '0;
        retire_t_old    = '0;
        retire_dest_idx = '0;
        if (retire_en) begin
            retire_t        = r_t[w_head_idx];
            retire_t_old    = r_t_old[w_head_idx];
            retire_dest_idx = r_dest[w_head_idx];
        end
    end

    // CDB match against pre-edge valid bits only.
    for (genvar g = 0; g < ROB_SZ; g++) begin : g_cam
        assign w_cam_hit[g] = complete_en & r_valid[g]
                            & (r_t[g].phys_reg == complete_t.phys_reg);
    end

    assign w_count_next = r_count
                        + (ROB_IDX_W + 1)'(w_dispatch_accept)
                        - (ROB_IDX_W + 1)'(retire_en);

    always_ff @(posedge clock) begin
        if (reset || squash_en) begin
            r_valid    <= '0;
            r_complete <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_complete <= r_complete | w_cam_hit;

            if (retire_en) begin
                r_valid[w_head_idx] <= 1'b0;
                r_head              <= r_head + 1'b1;
            end

            // Tail differs from head whenever dispatch is accepted and the head retires.
            if (w_dispatch_accept) begin
                r_valid[w_tail_idx]    <= 1'b1;
                r_complete[w_tail_idx] <= 1'b0;
                r_t[w_tail_idx]        <= dispatch_t;
                r_t_old[w_tail_idx]    <= dispatch_t_old;
                r_dest[w_tail_idx]     <= dispatch_dest_idx;
                r_tail                 <= r_tail + 1'b1;
            end

            r_count <= w_count_next;
        end
    end

endmodule
